// File: rtl/final_fifo_link_endpoint_pkg.sv
// ---------------------------------------------------------------------------
// final_fifo_link_endpoint_pkg: derived link sizes and TX state type.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package final_fifo_link_endpoint_pkg;

  function automatic int final_fifo_width(input int dist_x, input int dist_z);
    int rounds;
    int addr_w;
    rounds = (dist_x > dist_z) ? dist_x : dist_z;
    addr_w = 3 * $clog2(rounds);
    return addr_w + 3 + $clog2(rounds * dist_z + 1);
  endfunction

  function automatic int num_flits(input int msg_w, input int link_w);
    return (msg_w + link_w - 1) / link_w;
  endfunction

  function automatic int credit_cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  localparam int FINAL_FIFO_WIDTH = final_fifo_width(5, 4);
  localparam int NUM_FLITS        = num_flits(FINAL_FIFO_WIDTH, 8);
  localparam int CREDIT_CNT_WIDTH = credit_cnt_width(4);

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/final_fifo_link_endpoint_rx_fifo.sv
// ---------------------------------------------------------------------------
// link_rx_fifo: synchronous FIFO holding reassembled messages awaiting pop.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module link_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/final_fifo_link_endpoint.sv
// ---------------------------------------------------------------------------
// final_fifo_link_endpoint: credit-based message serializer/reassembler link.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module final_fifo_link_endpoint
  import final_fifo_link_endpoint_pkg::*;
#(
  parameter int  CODE_DISTANCE_X = 5,
  parameter int  CODE_DISTANCE_Z = 4,
  parameter int  LINK_WIDTH      = 8,
  parameter int  CREDITS         = 4,
  localparam int FF_W            = final_fifo_width(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FF_W-1:0]       final_fifo_out_data,
  input  logic                  final_fifo_out_valid,
  output logic                  final_fifo_out_ready,
  output logic [FF_W-1:0]       final_fifo_in_data,
  output logic                  final_fifo_in_valid,
  input  logic                  final_fifo_in_ready,
  input  logic                  has_message_flying_local,
  input  logic                  has_odd_clusters_local,
  output logic                  has_message_flying_otherside,
  output logic                  has_odd_clusters_otherside,
  output logic [LINK_WIDTH-1:0] tx_flit,
  output logic                  tx_flit_valid,
  output logic                  tx_flit_last,
  output logic                  tx_credit,
  output logic [1:0]            tx_status,
  input  logic [LINK_WIDTH-1:0] rx_flit,
  input  logic                  rx_flit_valid,
  input  logic                  rx_flit_last,
  input  logic                  rx_credit,
  input  logic [1:0]            rx_status,
  output logic                  link_error
);
  localparam int NF    = num_flits(FF_W, LINK_WIDTH);
  localparam int MSG_W = NF * LINK_WIDTH;
  localparam int IDX_W = (NF > 1) ? $clog2(NF) : 1;
  localparam int CCW   = credit_cnt_width(CREDITS);

  tx_state_e        state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CCW-1:0]   credit_q, credit_d;
  logic [IDX_W-1:0] rx_count_q, rx_count_d;
  logic [MSG_W-1:0] asm_q, asm_d;
  logic             link_error_q, link_error_d;
  logic             tx_credit_q;
  logic [1:0]       tx_status_q, rx_status_q;

  logic             accept, credit_err, rx_frame_err, rx_push_req;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [MSG_W-1:0] rx_shift;

  // Ready is forced low while reset is held so nothing is offered before init.
  assign final_fifo_out_ready = reset && (state_q == TX_IDLE) && (credit_q != '0);
  assign accept               = final_fifo_out_valid && final_fifo_out_ready;

  assign tx_flit_valid = (state_q == TX_SEND);
  assign tx_flit       = tx_flit_valid ? msg_q[LINK_WIDTH-1:0] : '0;
  assign tx_flit_last  = tx_flit_valid && (idx_q == IDX_W'(NF - 1));

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    idx_d      = idx_q;
    credit_d   = credit_q;
    credit_err = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          msg_d   = MSG_W'(final_fifo_out_data);
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        msg_d = msg_q >> LINK_WIDTH;
        if (idx_q == IDX_W'(NF - 1)) begin
          state_d = TX_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (rx_credit && !accept) begin
      if (credit_q == CCW'(CREDITS)) begin
        credit_err = 1'b1;
      end else begin
        credit_d = credit_q + CCW'(1);
      end
    end else if (!rx_credit && accept) begin
      credit_d = credit_q - CCW'(1);
    end
  end

  // Flits enter at the top and shift down, so the first flit ends up in the LSBs.
  assign rx_shift = MSG_W'({rx_flit, asm_q} >> LINK_WIDTH);

  always_comb begin
    rx_count_d   = rx_count_q;
    asm_d        = asm_q;
    rx_push_req  = 1'b0;
    rx_frame_err = 1'b0;
    if (rx_flit_valid) begin
      if (rx_flit_last) begin
        rx_count_d = '0;
        if (rx_count_q == IDX_W'(NF - 1)) begin
          rx_push_req = 1'b1;
        end else begin
          rx_frame_err = 1'b1;
        end
      end else if (rx_count_q == IDX_W'(NF - 1)) begin
        rx_count_d   = '0;
        rx_frame_err = 1'b1;
      end else begin
        asm_d      = rx_shift;
        rx_count_d = rx_count_q + IDX_W'(1);
      end
    end
    link_error_d = link_error_q | credit_err | rx_frame_err | (rx_push_req && fifo_full);
  end

  assign fifo_push = rx_push_req && !fifo_full;
  assign fifo_pop  = !fifo_empty && final_fifo_in_ready;

  link_rx_fifo #(
    .DEPTH (CREDITS),
    .WIDTH (FF_W)
  ) u_rx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (FF_W'(rx_shift)),
    .pop_i       (fifo_pop),
    .pop_data_o  (final_fifo_in_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= TX_IDLE;
      msg_q        <= '0;
      idx_q        <= '0;
      credit_q     <= CCW'(CREDITS);
      rx_count_q   <= '0;
      asm_q        <= '0;
      link_error_q <= 1'b0;
      tx_credit_q  <= 1'b0;
      tx_status_q  <= '0;
      rx_status_q  <= '0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      idx_q        <= idx_d;
      credit_q     <= credit_d;
      rx_count_q   <= rx_count_d;
      asm_q        <= asm_d;
      link_error_q <= link_error_d;
      tx_credit_q  <= fifo_pop;
      tx_status_q  <= {has_odd_clusters_local, has_message_flying_local};
      rx_status_q  <= rx_status;
    end
  end

  assign final_fifo_in_valid          = !fifo_empty;
  assign tx_credit                    = tx_credit_q;
  assign tx_status                    = tx_status_q;
  assign link_error                   = link_error_q;
  assign has_odd_clusters_otherside   = rx_status_q[1];
  assign has_message_flying_otherside = rx_status_q[0] | (state_q == TX_SEND) | !fifo_empty
                                      | (rx_count_q != '0) | (credit_q != CCW'(CREDITS));

endmodule

`default_nettype wire

// File: tb/tb_final_fifo_link_endpoint.sv
// ---------------------------------------------------------------------------
// tb_final_fifo_link_endpoint: loopback / directed bench with message model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_final_fifo_link_endpoint;
  import final_fifo_link_endpoint_pkg::*;

  localparam int FFW = FINAL_FIFO_WIDTH;

  logic           clk = 1'b0;
  logic           reset;
  logic [FFW-1:0] out_data, in_data;
  logic           out_valid, out_ready, in_valid, in_ready;
  logic           flying_local, odd_local, flying_other, odd_other;
  logic [7:0]     tx_flit, rx_flit, drv_flit;
  logic           tx_flit_valid, tx_flit_last, tx_credit;
  logic           rx_flit_valid, rx_flit_last, rx_credit;
  logic [1:0]     tx_status, rx_status, drv_status;
  logic           drv_valid, drv_last, drv_credit, link_error, loop;

  int             errors = 0;
  int             checks = 0;
  int             model_credits;
  logic [FFW-1:0] exp_q[$];
  logic [FFW-1:0] m;
  bit             acc;

  assign rx_flit       = loop ? tx_flit       : drv_flit;
  assign rx_flit_valid = loop ? tx_flit_valid : drv_valid;
  assign rx_flit_last  = loop ? tx_flit_last  : drv_last;
  assign rx_credit     = loop ? tx_credit     : drv_credit;
  assign rx_status     = loop ? tx_status     : drv_status;

  final_fifo_link_endpoint dut (
    .clk                          (clk),
    .reset                        (reset),
    .final_fifo_out_data          (out_data),
    .final_fifo_out_valid         (out_valid),
    .final_fifo_out_ready         (out_ready),
    .final_fifo_in_data           (in_data),
    .final_fifo_in_valid          (in_valid),
    .final_fifo_in_ready          (in_ready),
    .has_message_flying_local     (flying_local),
    .has_odd_clusters_local       (odd_local),
    .has_message_flying_otherside (flying_other),
    .has_odd_clusters_otherside   (odd_other),
    .tx_flit                      (tx_flit),
    .tx_flit_valid                (tx_flit_valid),
    .tx_flit_last                 (tx_flit_last),
    .tx_credit                    (tx_credit),
    .tx_status                    (tx_status),
    .rx_flit                      (rx_flit),
    .rx_flit_valid                (rx_flit_valid),
    .rx_flit_last                 (rx_flit_last),
    .rx_credit                    (rx_credit),
    .rx_status                    (rx_status),
    .link_error                   (link_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers msg for up to 'bound' cycles; on acceptance checks the three flits.
  task automatic send(input logic [FFW-1:0] msg, input int bound, input string tag, output bit ok);
    bit exp_ok;
    exp_ok    = (model_credits > 0);
    ok        = 1'b0;
    out_data  = msg;
    out_valid = 1'b1;
    for (int n = 0; n < bound && !ok; n++) begin
      #1;
      if (out_ready) ok = 1'b1;
      step();
    end
    out_valid = 1'b0;
    chk(tag, 32'(ok), 32'(exp_ok));
    if (ok) begin
      model_credits--;
      if (loop) exp_q.push_back(msg);
      for (int i = 0; i < NUM_FLITS; i++) begin
        #1;
        chk({tag, "_fv"}, 32'(tx_flit_valid), 32'd1);
        chk({tag, "_flit"}, 32'(tx_flit), (32'(msg) >> (8 * i)) & 32'hFF);
        chk({tag, "_last"}, 32'(tx_flit_last), 32'(i == NUM_FLITS - 1));
        step();
      end
    end
  endtask

  task automatic drain();
    in_ready = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
      #1;
      if (in_valid) begin
        chk("drain_data", 32'(in_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        model_credits++;
      end
      step();
    end
    in_ready = 1'b0;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; out_data = '0; out_valid = 1'b0; in_ready = 1'b0;
    flying_local = 1'b0; odd_local = 1'b0; loop = 1'b1;
    drv_flit = '0; drv_valid = 1'b0; drv_last = 1'b0; drv_credit = 1'b0; drv_status = '0;
    model_credits = 4;

    // Reset state
    repeat (3) step();
    #1;
    chk("rst_ready", 32'(out_ready), 0);
    chk("rst_in_valid", 32'(in_valid), 0);
    chk("rst_in_data", 32'(in_data), 0);
    chk("rst_flit", {tx_flit, 5'b0, tx_flit_valid, tx_flit_last, tx_credit}, 0);
    chk("rst_status", {28'b0, tx_status, flying_other, odd_other}, 0);
    chk("rst_err", 32'(link_error), 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(out_ready), 1);
    step();

    // Loopback of the reference message
    send(17'h15A3C, 10, "ref_send", acc);
    #1;
    chk("ref_rx_valid", 32'(in_valid), 1);
    chk("ref_rx_data", 32'(in_data), 32'h15A3C);
    step();
    drain();
    repeat (3) step();
    #1;
    chk("idle_flying", 32'(flying_other), 0);
    step();

    // Random loopback batches
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        m = FFW'($urandom());
        send(m, 10, "rnd_send", acc);
      end
      drain();
    end
    repeat (3) step();

    // Fill receive buffer with consumer stalled
    for (int k = 0; k < 5; k++) begin
      m = FFW'($urandom());
      send(m, 12, "fill_send", acc);
    end
    #1;
    chk("fill_flying", 32'(flying_other), 1);
    chk("fill_head", 32'(in_data), 32'(exp_q[0]));
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    void'(exp_q.pop_front());
    model_credits++;
    #1;
    chk("pop_credit", 32'(tx_credit), 1);
    step();
    send(m, 12, "fifth_send", acc);
    #1;
    chk("fifth_flying", 32'(flying_other), 1);
    drain();
    repeat (3) step();
    #1;
    chk("drained_flying", 32'(flying_other), 0);
    step();

    // Credit arriving in the accept cycle leaves the count unchanged
    loop = 1'b0;
    send(FFW'($urandom()), 10, "cr_send1", acc);
    send(FFW'($urandom()), 10, "cr_send2", acc);
    out_data = FFW'($urandom());
    out_valid = 1'b1;
    #1;
    chk("cr_same_ready", 32'(out_ready), 1);
    drv_credit = 1'b1;
    step();
    drv_credit = 1'b0;
    out_valid = 1'b0;
    repeat (NUM_FLITS) step();
    send(FFW'($urandom()), 10, "cr_send3", acc);
    send(FFW'($urandom()), 10, "cr_send4", acc);
    send(FFW'($urandom()), 10, "cr_stall", acc);
    drv_credit = 1'b1;
    repeat (4) step();
    drv_credit = 1'b0;
    model_credits = 4;
    step();

    // Malformed short frame, then an overlong frame, then a good frame
    #1;
    chk("pre_err", 32'(link_error), 0);
    drv_valid = 1'b1; drv_flit = 8'hAA; drv_last = 1'b0;
    step();
    drv_flit = 8'hBB; drv_last = 1'b1;
    step();
    drv_valid = 1'b0; drv_last = 1'b0;
    #1;
    chk("short_valid", 32'(in_valid), 0);
    chk("short_err", 32'(link_error), 1);
    step();
    step();
    #1;
    chk("err_sticky", 32'(link_error), 1);
    drv_valid = 1'b1;
    for (int i = 0; i < NUM_FLITS; i++) begin
      drv_flit = 8'($urandom());
      step();
    end
    m = FFW'($urandom());
    for (int i = 0; i < NUM_FLITS; i++) begin
      drv_flit = 8'(32'(m) >> (8 * i));
      drv_last = (i == NUM_FLITS - 1);
      step();
    end
    drv_valid = 1'b0; drv_last = 1'b0;
    #1;
    chk("good_valid", 32'(in_valid), 1);
    chk("good_data", 32'(in_data), 32'(m));
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    #1;
    chk("good_credit", 32'(tx_credit), 1);
    chk("good_popped", 32'(in_valid), 0);
    step();

    // Status path latency in loopback
    loop = 1'b1;
    step();
    odd_local = 1'b1; flying_local = 1'b1;
    step();
    #1;
    chk("odd_c1", 32'(odd_other), 0);
    chk("fly_c1", 32'(flying_other), 0);
    step();
    #1;
    chk("odd_c2", 32'(odd_other), 1);
    chk("fly_c2", 32'(flying_other), 1);
    odd_local = 1'b0; flying_local = 1'b0;
    step();
    #1;
    chk("odd_d1", 32'(odd_other), 1);
    step();
    #1;
    chk("odd_d2", 32'(odd_other), 0);
    chk("fly_d2", 32'(flying_other), 0);

    // Credit overflow after a fresh reset
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    chk("rst2_err", 32'(link_error), 0);
    loop = 1'b0;
    drv_credit = 1'b1;
    step();
    drv_credit = 1'b0;
    #1;
    chk("ovf_err", 32'(link_error), 1);
    chk("ovf_ready", 32'(out_ready), 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
